// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions: opcodes, command-type codes, loader FSM
// state encoding and the instruction encoder used ahead of the write buffer.
package mips_pkg;

  localparam logic [5:0] OP_R  = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_JZ = 6'b000010;

  localparam logic [1:0] CMD_R  = 2'b00;
  localparam logic [1:0] CMD_JZ = 2'b01;
  localparam logic [1:0] CMD_SW = 2'b10;
  localparam logic [1:0] CMD_LW = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // JZ carries no rt: that field is forced to zero regardless of the input.
  function automatic logic [31:0] encode_instr(input logic [1:0]  cmd_type,
                                               input logic [4:0]  rs,
                                               input logic [4:0]  rt,
                                               input logic [4:0]  rd,
                                               input logic [5:0]  funct,
                                               input logic [15:0] imm);
    logic [31:0] word;
    case (cmd_type)
      CMD_R:   word = {OP_R, rs, rt, rd, 5'b00000, funct};
      CMD_JZ:  word = {OP_JZ, rs, 5'b00000, imm};
      CMD_SW:  word = {OP_SW, rs, rt, imm};
      default: word = {OP_LW, rs, rt, imm};
    endcase
    return word;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with full/empty flags; push is dropped when full and pop
// when empty, so the occupancy can never overflow or underflow.
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes incoming instruction commands, buffers them and streams them into
// instruction memory from a start address, honouring memory stalls.
module instr_encoder_loader
  import mips_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic              cmd_last,
  input  logic              imem_stall,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              wrapped,
  output logic [ADDR_W:0]   word_count
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   wcount_q;
  logic              wrapped_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;

  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_rdata;
  logic [31:0] enc_word;
  logic        accept, pop, start_ok;

  assign enc_word  = encode_instr(cmd_type, rs, rt, rd, funct, imm);
  assign cmd_ready = (state_q == ST_LOAD) && !fifo_full;
  assign accept    = cmd_valid && cmd_ready;
  assign pop       = !fifo_empty && !imem_stall;
  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  instr_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (reset),
    .push (accept),
    .pop  (pop),
    .wdata(enc_word),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_LOAD;
      ST_LOAD:  if (accept && cmd_last) state_d = ST_DRAIN;
      // An empty buffer here means the final word is being written this cycle.
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      default:  if (start_ok) state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wcount_q  <= '0;
      wrapped_q <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= pop;
      if (pop) begin
        waddr_q <= addr_q;
        wdata_q <= fifo_rdata;
      end
      if (start_ok) begin
        addr_q    <= base_addr;
        wcount_q  <= '0;
        wrapped_q <= 1'b0;
      end else if (pop) begin
        addr_q   <= addr_q + ADDR_W'(1);
        wcount_q <= wcount_q + (ADDR_W+1)'(1);
        if (&addr_q) wrapped_q <= 1'b1;
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign done       = (state_q == ST_DONE);
  assign wrapped    = wrapped_q;
  assign word_count = wcount_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: expected writes are queued when a
// command is accepted and matched by a monitor watching imem_we.
module tb_instr_encoder_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_type;
  logic [4:0]    rs, rt, rd;
  logic [5:0]    funct;
  logic [15:0]   imm;
  logic          cmd_last;
  logic          imem_stall;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          done;
  logic          wrapped;
  logic [AW:0]   word_count;

  int n_vec = 0;
  int n_bad = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW-1:0]  exp_addr = '0;

  instr_encoder_loader #(.FIFO_DEPTH(4), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .cmd_last(cmd_last),
    .imem_stall(imem_stall), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .done(done), .wrapped(wrapped),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [AW+31:0] e;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, want no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e[AW+31:32]));
        check("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
    exp_addr = base;
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [4:0] s, input logic [4:0] tt,
                          input logic [4:0] d, input logic [5:0] f, input logic [15:0] im,
                          input logic last, input logic [31:0] expw, input bit track);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_type = t; rs = s; rt = tt; rd = d; funct = f; imm = im; cmd_last = last;
    while (cmd_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL cmd_accept: cmd_ready stayed 0x%0h, want 0x1 within 50 cycles", cmd_ready);
    end else begin
      if (track) begin
        exp_q.push_back({exp_addr, expw});
        exp_addr++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    cmd_last = 1'b0;
  endtask

  task automatic wait_done();
    int w = 0;
    while (done !== 1'b1 && w < 60) begin
      tick();
      w++;
    end
    check("done", 32'(done), 32'h1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; cmd_valid = 1'b0;
    cmd_type = 2'b00; rs = '0; rt = '0; rd = '0; funct = '0; imm = '0;
    cmd_last = 1'b0; imem_stall = 1'b0;
    #2;
    check("rst_we", 32'(imem_we), 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_wrapped", 32'(wrapped), 32'h0);
    check("rst_wcount", 32'(word_count), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'h0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("idle_ready", 32'(cmd_ready), 32'h0);

    // Single R instruction, with the two-cycle latency observed directly.
    do_start(8'h10);
    check("load_ready", 32'(cmd_ready), 32'h1);
    send_cmd(2'b00, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 1'b1, 32'h00221820, 1'b1);
    check("lat_k", 32'(imem_we), 32'h0);
    tick();
    check("lat_k1", 32'(imem_we), 32'h1);
    check("drain_ready", 32'(cmd_ready), 32'h0);
    wait_done();
    check("r_wcount", 32'(word_count), 32'h1);
    check("done_ready", 32'(cmd_ready), 32'h0);

    // LW then SW back to back.
    do_start(8'h20);
    check("restart_done", 32'(done), 32'h0);
    check("restart_wcount", 32'(word_count), 32'h0);
    send_cmd(2'b11, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0004, 1'b0, 32'h8C220004, 1'b1);
    send_cmd(2'b10, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0004, 1'b1, 32'hAC220004, 1'b1);
    check("b2b_we0", 32'(imem_we), 32'h1);
    tick();
    check("b2b_we1", 32'(imem_we), 32'h1);
    check("b2b_addr1", 32'(imem_addr), 32'h21);
    wait_done();
    check("lwsw_wcount", 32'(word_count), 32'h2);

    // JZ under a 3-cycle stall, then fill the buffer while stalled.
    do_start(8'h30);
    imem_stall = 1'b1;
    send_cmd(2'b01, 5'd4, 5'd0, 5'd0, 6'h0, 16'hFFFE, 1'b0, 32'h0880FFFE, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("stall_no_we", 32'(imem_we), 32'h0);
      tick();
    end
    imem_stall = 1'b0;
    tick();
    check("stall_release_we", 32'(imem_we), 32'h1);
    tick();
    check("single_write", 32'(imem_we), 32'h0);
    imem_stall = 1'b1;
    send_cmd(2'b01, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0001, 1'b0, 32'h08800001, 1'b1);
    send_cmd(2'b01, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0002, 1'b0, 32'h08800002, 1'b1);
    send_cmd(2'b01, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0003, 1'b0, 32'h08800003, 1'b1);
    send_cmd(2'b01, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0004, 1'b0, 32'h08800004, 1'b1);
    check("full_ready", 32'(cmd_ready), 32'h0);
    check("full_no_we", 32'(imem_we), 32'h0);
    tick();
    check("full_wcount", 32'(word_count), 32'h1);
    imem_stall = 1'b0;
    send_cmd(2'b01, 5'd31, 5'd31, 5'd0, 6'h0, 16'h0001, 1'b1, 32'h0BE00001, 1'b1);
    wait_done();
    check("jz_wcount", 32'(word_count), 32'h6);

    // Address wrap from 0xFE.
    do_start(8'hFE);
    check("wrap_clear", 32'(wrapped), 32'h0);
    send_cmd(2'b00, 5'd5, 5'd6, 5'd7, 6'h22, 16'hFFFF, 1'b0, 32'h00A63822, 1'b1);
    send_cmd(2'b11, 5'd0, 5'd9, 5'd0, 6'h0, 16'h1234, 1'b0, 32'h8C091234, 1'b1);
    send_cmd(2'b10, 5'd31, 5'd31, 5'd0, 6'h0, 16'hFFFF, 1'b1, 32'hAFFFFFFF, 1'b1);
    wait_done();
    check("wrap_flag", 32'(wrapped), 32'h1);
    check("wrap_wcount", 32'(word_count), 32'h3);

    // Start during LOAD is ignored.
    do_start(8'h40);
    check("wrap_cleared", 32'(wrapped), 32'h0);
    send_cmd(2'b00, 5'd0, 5'd0, 5'd31, 6'h3F, 16'h0, 1'b0, 32'h0000F83F, 1'b1);
    tick();
    start = 1'b1; base_addr = 8'h80;
    tick();
    start = 1'b0;
    check("ign_ready", 32'(cmd_ready), 32'h1);
    check("ign_wcount", 32'(word_count), 32'h1);
    send_cmd(2'b01, 5'd31, 5'd31, 5'd0, 6'h0, 16'h0001, 1'b1, 32'h0BE00001, 1'b1);
    wait_done();
    check("ign_addr", 32'(imem_addr), 32'h41);
    check("ign_wcount2", 32'(word_count), 32'h2);

    // Reset mid-session with a write in flight and two words buffered.
    do_start(8'h50);
    imem_stall = 1'b1;
    send_cmd(2'b00, 5'd1, 5'd1, 5'd1, 6'h1, 16'h0, 1'b0, 32'h0, 1'b0);
    send_cmd(2'b00, 5'd2, 5'd2, 5'd2, 6'h2, 16'h0, 1'b0, 32'h0, 1'b0);
    send_cmd(2'b00, 5'd3, 5'd3, 5'd3, 6'h3, 16'h0, 1'b0, 32'h0, 1'b0);
    imem_stall = 1'b0;
    tick();
    check("pre_rst_we", 32'(imem_we), 32'h1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_we", 32'(imem_we), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    check("mid_rst_ready", 32'(cmd_ready), 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("post_rst_ready", 32'(cmd_ready), 32'h0);
    check("post_rst_done", 32'(done), 32'h0);
    check("post_rst_wcount", 32'(word_count), 32'h0);

    // Resume on a fresh start.
    do_start(8'h60);
    send_cmd(2'b11, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0004, 1'b1, 32'h8C220004, 1'b1);
    wait_done();
    check("resume_wcount", 32'(word_count), 32'h1);
    tick(); tick();
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: encoded-word buffer entries, a power of two and at least 2.
REQ-002 SHALL have parameter ADDR_W, default 8: instruction-memory word-address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle load-session start pulse.
REQ-006 SHALL have port base_addr  input  ADDR_W  first write address, sampled on the accepted start.
REQ-007 SHALL have ports cmd_valid  input  1, and cmd_ready  output  1: command handshake.
REQ-008 SHALL have port cmd_type  input  2  instruction type: 00 R, 01 JZ, 10 SW, 11 LW.
REQ-009 SHALL have ports rs, rt, rd  input  5 each, and funct  input  6: register and function fields.
REQ-010 SHALL have ports imm  input  16  immediate, and cmd_last  input  1  marks the final command.
REQ-011 SHALL have port imem_stall  input  1  memory not able to take a write this cycle.
REQ-012 SHALL have ports imem_we  output  1, imem_addr  output  ADDR_W, and imem_wdata  output  32: the memory write port.
REQ-013 SHALL have ports done  output  1  session complete, wrapped  output  1  sticky address-wrap flag, and word_count  output  ADDR_W+1  number of words written this session.

Function
REQ-014 SHALL encode R as {000000, rs, rt, rd, 00000, funct}.
REQ-015 SHALL encode LW as {100011, rs, rt, imm}, SW as {101011, rs, rt, imm}, and JZ as {000010, rs, 00000, imm}.
REQ-016 SHALL implement the FSM states IDLE, LOAD, DRAIN and DONE.
REQ-017 SHALL, on start in IDLE or DONE, go to LOAD, load the address counter from base_addr, and clear done, wrapped and word_count; start in LOAD or DRAIN SHALL be ignored.
REQ-018 SHALL drive cmd_ready = (state==LOAD) && FIFO not full, and SHALL accept a command only when cmd_valid && cmd_ready.
REQ-019 SHALL push the encoded word into the FIFO on the accepting edge; an accepted command with cmd_last=1 SHALL move the FSM LOAD->DRAIN.
REQ-020 SHALL pop one word per cycle when the FIFO is non-empty and imem_stall=0, and SHALL register it onto imem_wdata/imem_addr with imem_we=1 for exactly that one cycle.
REQ-021 SHALL give a latency of 2 cycles from accept to imem_we when there is no stall: accept at edge k, imem_we high after edge k+1.
REQ-022 SHALL hold imem_we=0 while imem_stall=1, with no pop and the FIFO and address unchanged.
REQ-023 SHALL, on a simultaneous push and pop, leave the occupancy unchanged; the FIFO SHALL never overflow or underflow.
REQ-024 SHALL increment the address and word_count after each write.
REQ-025 SHALL wrap the address from 2^ADDR_W-1 to 0 and set wrapped, which holds until the next start or reset.
REQ-026 SHALL go DRAIN->DONE on the edge after the last write, once the FIFO is empty and no write is pending; done SHALL be 1 in DONE only.
REQ-027 SHALL keep cmd_ready=0 in IDLE, DRAIN and DONE.

Reset
REQ-028 SHALL, on reset, immediately put the FSM in IDLE, empty the FIFO, and zero the address counter, imem_we, imem_addr, imem_wdata, done, wrapped, word_count and cmd_ready.
REQ-029 SHALL, on reset mid-session, discard all buffered words, perform no further writes, and resume only on a new start.

Structure
REQ-030 SHALL take from a shared package mips_pkg: the opcode constants (R 000000, LW 100011, SW 101011, JZ 000010), the cmd_type encodings, and the FSM state encoding.
REQ-031 SHALL implement the buffer as sub-module instr_fifo (synchronous, parameterised width and depth, full/empty flags, async active-high reset).
REQ-032 SHALL keep the encoding combinational ahead of the FIFO push.

Verification
REQ-033 SHALL cover: start with base_addr=0x10, then R with rs=1, rt=2, rd=3, funct=0x20, cmd_last=1 -> imem_we at addr 0x10 with data 0x00221820, then done=1 and word_count=1.
REQ-034 SHALL cover: LW then SW, each with rs=1, rt=2, imm=4 -> 0x8C220004 at base and 0xAC220004 at base+1, back-to-back cycles.
REQ-035 SHALL cover: JZ with rs=4, imm=0xFFFE and imem_stall held for 3 cycles -> no write during the stall, then a single write of 0x0880FFFE, and cmd_ready low once the FIFO is full.
REQ-036 SHALL cover: base_addr=0xFE and 3 commands -> writes at 0xFE, 0xFF, 0x00, with wrapped=1 and word_count=3.
REQ-037 SHALL cover: reset asserted with 2 words buffered -> imem_we=0 immediately, no further writes, state IDLE, done=0.
REQ-038 SHALL cover: start pulsed during LOAD -> ignored, with address and word_count unaffected.
